// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//   Bus initiator for simulation benches. Replays a fixed list of memory-bus
//   writes and read-compares packed into the seq_content parameter, standing in
//   for a CPU so a memory-mapped target can be exercised without a program ROM.
//
//   Entry i occupies seq_content[(i+1)*E-1 : i*E], E = 1+addr_size+word_size,
//   laid out as {op, addr, data}; op=1 is a write, op=0 a read-compare.
//   A write entry owns the bus for one cycle, a read entry for two: the address
//   cycle, then a wait cycle at whose end data_in is compared against data.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   start       in   begin/restart the sequence (honoured only in IDLE/DONE)
//   data_in     in   read data, valid the cycle after addr is presented
//   addr        out  bus address (registered)
//   data_out    out  write data (registered, 0 during reads)
//   write_en    out  one-cycle write strobe per write entry
//   busy        out  sequence in progress
//   done        out  sequence finished, held until restart/reset
//   content_ok  out  cleared by the first read-compare mismatch (sticky)
//   err_index   out  index of the first mismatching entry
// -----------------------------------------------------------------------------
module bus_sequencer #(
   parameter int addr_size = 8,
   parameter int word_size = 8,
   parameter int seq_len   = 4,
   parameter logic [seq_len*(1+addr_size+word_size)-1:0] seq_content = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [word_size-1:0] data_in,
   output logic [addr_size-1:0] addr,
   output logic [word_size-1:0] data_out,
   output logic                 write_en,
   output logic                 busy,
   output logic                 done,
   output logic                 content_ok,
   output logic [((seq_len > 1) ? $clog2(seq_len) : 1)-1:0] err_index
);

   localparam int entry_w = 1 + addr_size + word_size;
   localparam int idx_w   = (seq_len > 1) ? $clog2(seq_len) : 1;
   localparam logic [idx_w-1:0] last_idx = idx_w'(seq_len - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t               state, state_n;
   logic [idx_w-1:0]     idx, idx_n, load_idx;
   logic [addr_size-1:0] addr_n;
   logic [word_size-1:0] data_out_n;
   logic                 write_en_n, busy_n, done_n, content_ok_n;
   logic [idx_w-1:0]     err_index_n;
   logic [entry_w-1:0]   load_entry;
   logic                 load, advance;

   // Fields of the entry currently on the bus.
   logic                 cur_op;
   logic [word_size-1:0] cur_data;

   assign cur_op   = seq_content[int'(idx)*entry_w + entry_w - 1];
   assign cur_data = seq_content[int'(idx)*entry_w +: word_size];

   always_comb begin
      // NOTE: every variable gets a default first so no path through this block
      // leaves one unassigned, which would infer a latch.
      state_n      = state;
      idx_n        = idx;
      addr_n       = addr;
      data_out_n   = data_out;
      write_en_n   = 1'b0;
      busy_n       = busy;
      done_n       = done;
      content_ok_n = content_ok;
      err_index_n  = err_index;
      load         = 1'b0;
      advance      = 1'b0;
      load_idx     = '0;
      load_entry   = '0;

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               load         = 1'b1;
               load_idx     = '0;
               busy_n       = 1'b1;
               done_n       = 1'b0;
               content_ok_n = 1'b1;
               err_index_n  = '0;
            end
         end
         ISSUE: begin
            if (cur_op) advance = 1'b1;
            else        state_n = WAIT;
         end
         WAIT: begin
            // Only the first mismatch is recorded; later ones leave err_index alone.
            if (data_in != cur_data && content_ok) begin
               content_ok_n = 1'b0;
               err_index_n  = idx;
            end
            advance = 1'b1;
         end
         default: state_n = IDLE;
      endcase

      // Leaving an entry: either finish or present the next one, never wrap.
      if (advance) begin
         if (idx == last_idx) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end else begin
            load     = 1'b1;
            load_idx = idx + 1'b1;
         end
      end

      // Outputs are registered, so the entry is loaded on the edge entering ISSUE
      // and is visible on the bus for the whole ISSUE cycle.
      if (load) begin
         load_entry = seq_content[int'(load_idx)*entry_w +: entry_w];
         state_n    = ISSUE;
         idx_n      = load_idx;
         addr_n     = load_entry[entry_w-2 -: addr_size];
         write_en_n = load_entry[entry_w-1];
         data_out_n = load_entry[entry_w-1] ? load_entry[word_size-1:0] : '0;
      end
   end

   // NOTE: non-blocking assignments make every register sample the pre-edge
   // values, so register-to-register order inside this block does not matter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         addr       <= '0;
         data_out   <= '0;
         write_en   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         content_ok <= 1'b1;
         err_index  <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         addr       <= addr_n;
         data_out   <= data_out_n;
         write_en   <= write_en_n;
         busy       <= busy_n;
         done       <= done_n;
         content_ok <= content_ok_n;
         err_index  <= err_index_n;
      end
   end

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
//   Drives bus_sequencer against an 8-bit synchronous RAM with a per-address
//   corruption mask. A queue-based model expands the entry list into the
//   expected per-cycle bus activity whenever a start is accepted; a compare
//   process checks every output against it on each falling edge. Directed
//   tests add hand-computed expectations (latency, strobe pattern, err_index).
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

   localparam int n_ent = 4;
   // {R 0x81==0x07, R 0x80==0x64, W 0x81<=0x07, W 0x80<=0x64}, entry 0 in the LSBs.
   localparam logic [67:0] seq = {1'b0, 8'h81, 8'h07,
                                  1'b0, 8'h80, 8'h64,
                                  1'b1, 8'h81, 8'h07,
                                  1'b1, 8'h80, 8'h64};
   localparam bit         ent_op   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [7:0] ent_addr [4] = '{8'h80, 8'h81, 8'h80, 8'h81};
   localparam logic [7:0] ent_data [4] = '{8'h64, 8'h07, 8'h64, 8'h07};

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] data_in, addr, data_out;
   logic       write_en, busy, done, content_ok;
   logic [1:0] err_index;

   bus_sequencer #(
      .addr_size  (8),
      .word_size  (8),
      .seq_len    (4),
      .seq_content(seq)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data_in   (data_in),
      .addr      (addr),
      .data_out  (data_out),
      .write_en  (write_en),
      .busy      (busy),
      .done      (done),
      .content_ok(content_ok),
      .err_index (err_index)
   );

   always #5 clk = ~clk;

   // Target RAM: read data appears the cycle after the address.
   logic [7:0] mem     [256];
   logic [7:0] corrupt [256];

   always @(posedge clk) begin
      if (write_en) mem[addr] <= data_out;
      data_in <= mem[addr] ^ corrupt[addr];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic       we;
      logic       bsy;
      logic       dn;
      logic       ok;
      logic [1:0] err;
   } cyc_t;

   cyc_t       plan [$];
   logic [7:0] ref_mem [256];
   logic       model_valid = 1'b0;
   logic [7:0] m_addr, m_dout;
   logic       m_we, m_busy, m_done, m_ok;
   logic [1:0] m_err;

   function automatic cyc_t mk(input logic [7:0] a, input logic [7:0] d, input logic we,
                               input logic bsy, input logic dn, input logic ok,
                               input logic [1:0] err);
      cyc_t c;
      c.a = a; c.d = d; c.we = we; c.bsy = bsy; c.dn = dn; c.ok = ok; c.err = err;
      return c;
   endfunction

   // Expand the entry list into one record per bus cycle, ending with the DONE record.
   task automatic build_plan();
      logic [7:0] shadow [256];
      logic       ok_r;
      logic [1:0] err_r;
      logic [7:0] last_a, last_d;
      shadow = ref_mem;
      ok_r   = 1'b1;
      err_r  = 2'd0;
      last_a = 8'h00;
      last_d = 8'h00;
      for (int i = 0; i < n_ent; i++) begin
         last_a = ent_addr[i];
         if (ent_op[i]) begin
            plan.push_back(mk(ent_addr[i], ent_data[i], 1'b1, 1'b1, 1'b0, ok_r, err_r));
            shadow[ent_addr[i]] = ent_data[i];
            last_d = ent_data[i];
         end else begin
            repeat (2) plan.push_back(mk(ent_addr[i], 8'h00, 1'b0, 1'b1, 1'b0, ok_r, err_r));
            if (((shadow[ent_addr[i]] ^ corrupt[ent_addr[i]]) != ent_data[i]) && ok_r) begin
               ok_r  = 1'b0;
               err_r = 2'(i);
            end
            last_d = 8'h00;
         end
      end
      plan.push_back(mk(last_a, last_d, 1'b0, 1'b0, 1'b1, ok_r, err_r));
   endtask

   always @(posedge clk) begin
      cyc_t c;
      model_valid = 1'b1;
      if (reset) begin
         plan.delete();
         m_addr = 8'h00; m_dout = 8'h00; m_we = 1'b0; m_busy = 1'b0;
         m_done = 1'b0;  m_ok   = 1'b1;  m_err = 2'd0;
      end else begin
         if (plan.size() == 0 && start) build_plan();
         if (plan.size() != 0) begin
            c = plan.pop_front();
            m_addr = c.a; m_dout = c.d; m_we = c.we; m_busy = c.bsy;
            m_done = c.dn; m_ok = c.ok; m_err = c.err;
            if (c.we) ref_mem[c.a] = c.d;
         end else begin
            m_we = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("cmp_addr",       32'(addr),       32'(m_addr));
         check("cmp_data_out",   32'(data_out),   32'(m_dout));
         check("cmp_write_en",   32'(write_en),   32'(m_we));
         check("cmp_busy",       32'(busy),       32'(m_busy));
         check("cmp_done",       32'(done),       32'(m_done));
         check("cmp_content_ok", 32'(content_ok), 32'(m_ok));
         check("cmp_err_index",  32'(err_index),  32'(m_err));
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at a falling edge. Pulses start, then watches until done.
   // lat = edges from the start edge to the edge that raised done.
   // we_hist bit n = write_en in the cycle after edge n (edge 0 = start edge).
   task automatic run_seq(input int poke_at, input int reset_at,
                          output int lat, output logic [15:0] we_hist);
      bit fin;
      fin     = 1'b0;
      lat     = -1;
      we_hist = '0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 40 && !fin; i++) begin
         if (i <= 16) we_hist[i-1] = write_en;
         if (i == 1) begin
            check("start_done_low", 32'(done), 32'd0);
            check("start_busy_high", 32'(busy), 32'd1);
         end
         if (done) begin
            lat = i - 1;
            fin = 1'b1;
         end else if (i == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst_mid_write_en", 32'(write_en), 32'd0);
            check("rst_mid_busy",     32'(busy),     32'd0);
            check("rst_mid_done",     32'(done),     32'd0);
            check("rst_mid_addr",     32'(addr),     32'd0);
            check("rst_mid_ok",       32'(content_ok), 32'd1);
            reset = 1'b0;
            fin   = 1'b1;
         end else begin
            if (i == poke_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      if (!fin) check("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      int          lat;
      int          dn_cnt;
      logic [15:0] we_hist;

      for (int i = 0; i < 256; i++) corrupt[i] = 8'h00;

      // 1. Reset held with start=1: everything at reset values.
      reset = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_addr",       32'(addr),       32'd0);
      check("rst_data_out",   32'(data_out),   32'd0);
      check("rst_write_en",   32'(write_en),   32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_content_ok", 32'(content_ok), 32'd1);
      check("rst_err_index",  32'(err_index),  32'd0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);

      // 2. Clean run: W,W,R,R costs 1+1+2+2 = 6 edges, writes back to back.
      run_seq(0, 0, lat, we_hist);
      check("t2_latency",   32'(lat),          32'd6);
      check("t2_we_pattern", 32'(we_hist[5:0]), 32'b000011);
      check("t2_content_ok", 32'(content_ok),  32'd1);
      repeat (3) @(negedge clk);
      check("t2_done_held", 32'(done),     32'd1);
      check("t2_addr_held", 32'(addr),     32'h81);
      check("t2_dout_held", 32'(data_out), 32'h00);

      // 3. RAM returns 0x65 at 0x80: entry 2 fails, entry 3 passes.
      corrupt[8'h80] = 8'h01;
      run_seq(0, 0, lat, we_hist);
      check("t3_latency",    32'(lat),        32'd6);
      check("t3_content_ok", 32'(content_ok), 32'd0);
      check("t3_err_index",  32'(err_index),  32'd2);

      // 4. Entries 2 and 3 both fail: the first one is kept.
      corrupt[8'h81] = 8'h10;
      run_seq(0, 0, lat, we_hist);
      check("t4_content_ok", 32'(content_ok), 32'd0);
      check("t4_err_index",  32'(err_index),  32'd2);
      corrupt[8'h80] = 8'h00;
      corrupt[8'h81] = 8'h00;

      // 5. Reset in the wait cycle of entry 2 (edge 3 after start), then replay.
      run_seq(0, 4, lat, we_hist);
      run_seq(0, 0, lat, we_hist);
      check("t5_latency",    32'(lat),        32'd6);
      check("t5_content_ok", 32'(content_ok), 32'd1);
      check("t5_we_pattern", 32'(we_hist[5:0]), 32'b000011);

      // 6. start pulsed while busy changes nothing.
      run_seq(2, 0, lat, we_hist);
      check("t6_poke_latency", 32'(lat),          32'd6);
      check("t6_poke_we",      32'(we_hist[5:0]), 32'b000011);

      // Held start in DONE: restart on every completion, done at edges 6 and 13.
      start  = 1'b1;
      dn_cnt = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done) dn_cnt++;
      end
      start = 1'b0;
      check("held_start_dones", 32'(dn_cnt), 32'd2);
      repeat (3) @(negedge clk);
      check("held_final_done", 32'(done), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
